// File: rtl/jpeg_fb_writer_pkg.sv
// Shared types and helpers for the JPEG framebuffer writer: RGB565 packing,
// byte-strobe constants and the word record carried through the output FIFO.
package jpeg_fb_pkg;

    localparam int FB_ADDR_W = 32;

    localparam logic [3:0] STRB_FULL = 4'hF;
    localparam logic [3:0] STRB_LO   = 4'h3;
    localparam logic [3:0] STRB_HI   = 4'hC;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [31:0]          data;
        logic [3:0]           strb;
    } fb_word_t;

    typedef enum logic {
        EMPTY,
        HELD
    } pair_state_t;

    function automatic logic [15:0] rgb_to_565(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
        return {5'(r >> 3), 6'(g >> 2), 5'(b >> 3)};
    endfunction

endpackage

// File: rtl/jpeg_fb_writer_if.sv
// Pixel-in and memory-write handshake bundle of the framebuffer writer.
// master is the writer itself; slave is the converter/memory side around it.
interface jpeg_fb_if #(
    parameter int ADDR_W = 32
) ();
    logic              InEnable;
    logic              InReady;
    logic [15:0]       InPixelX;
    logic [15:0]       InPixelY;
    logic [7:0]        InR;
    logic [7:0]        InG;
    logic [7:0]        InB;
    logic              WrValid;
    logic              WrReady;
    logic [ADDR_W-1:0] WrAddr;
    logic [31:0]       WrData;
    logic [3:0]        WrStrb;

    modport master (
        input  InEnable, InPixelX, InPixelY, InR, InG, InB, WrReady,
        output InReady, WrValid, WrAddr, WrData, WrStrb
    );

    modport slave (
        output InEnable, InPixelX, InPixelY, InR, InG, InB, WrReady,
        input  InReady, WrValid, WrAddr, WrData, WrStrb
    );
endinterface

// File: rtl/jpeg_fb_writer_fifo.sv
// First-word-fall-through FIFO of framebuffer words with two push ports
// (push1 lands behind push0 in the same cycle) and one pop port.
module jpeg_fb_fifo
    import jpeg_fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push0,
    input  fb_word_t                 push0_word,
    input  logic                     push1,
    input  fb_word_t                 push1_word,
    input  logic                     pop,
    output fb_word_t                 head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int PTR_W = $clog2(DEPTH);

    fb_word_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] wr_ptr1;
    logic [PTR_W:0]   n_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign wr_ptr1 = wr_ptr + PTR_W'(push0);
    assign n_push  = (PTR_W+1)'(push0) + (PTR_W+1)'(push1);
    assign empty   = (count == '0);
    assign free    = (PTR_W+1)'(DEPTH) - count;
    // Head reads as zero while empty so the write port is quiet when idle.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr]  <= push0_word;
        if (push1) mem[wr_ptr1] <= push1_word;
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count + n_push - (PTR_W+1)'(do_pop);
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst || clear)
        n_push <= free + (PTR_W+1)'(do_pop));

endmodule

// File: rtl/jpeg_fb_writer.sv
// Framebuffer writer: pairs RGB565 pixels into 32-bit words, computes their
// linear byte address and queues them for the memory write port.
module jpeg_fb_writer
    import jpeg_fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ProcessInit,
    input  logic [ADDR_W-1:0] FbBase,
    input  logic [15:0]       FbStride,
    input  logic              Flush,
    jpeg_fb_if.master         bus,
    output logic              Idle,
    output logic [31:0]       WordCount
);
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    pair_state_t       state;
    logic [15:0]       held_p;
    logic [15:0]       held_x;
    logic [15:0]       held_y;
    logic [FB_ADDR_W-1:0] held_addr;
    logic              in_ready;

    logic [15:0]       pix_p;
    logic [31:0]       lin_off;
    logic [FB_ADDR_W-1:0] pix_addr;
    logic              accept;
    logic              pop;
    logic              push0;
    logic              push1;
    fb_word_t          word0;
    fb_word_t          word1;
    fb_word_t          head;
    logic              hold_next;
    logic              load_held;
    logic              fifo_empty;
    logic [FREE_W-1:0] fifo_free;
    int                free_after;

    assign pix_p    = rgb_to_565(bus.InR, bus.InG, bus.InB);
    assign lin_off  = (32'(bus.InPixelY) * 32'(FbStride)
                       + 32'({bus.InPixelX[15:1], 1'b0})) << 1;
    assign pix_addr = FB_ADDR_W'(FbBase + ADDR_W'(lin_off));
    assign accept   = bus.InEnable && in_ready;
    assign pop      = bus.WrValid && bus.WrReady;

    // Pixel first, then flush on whatever the slot holds afterwards.
    always_comb begin
        push0     = 1'b0;
        push1     = 1'b0;
        word0     = '0;
        word1     = '0;
        load_held = 1'b0;
        hold_next = (state == HELD);
        if (accept) begin
            if (state == HELD && bus.InPixelY == held_y && bus.InPixelX == held_x + 16'd1) begin
                push0     = 1'b1;
                word0     = '{addr: held_addr, data: {pix_p, held_p}, strb: STRB_FULL};
                hold_next = 1'b0;
            end else begin
                if (state == HELD) begin
                    push0 = 1'b1;
                    word0 = '{addr: held_addr, data: {16'h0, held_p}, strb: STRB_LO};
                end
                if (!bus.InPixelX[0]) begin
                    load_held = 1'b1;
                    hold_next = 1'b1;
                end else begin
                    hold_next = 1'b0;
                    if (state == HELD) begin
                        push1 = 1'b1;
                        word1 = '{addr: pix_addr, data: {pix_p, 16'h0}, strb: STRB_HI};
                    end else begin
                        push0 = 1'b1;
                        word0 = '{addr: pix_addr, data: {pix_p, 16'h0}, strb: STRB_HI};
                    end
                end
            end
        end
        if (Flush && hold_next) begin
            hold_next = 1'b0;
            if (!push0) begin
                push0 = 1'b1;
                word0 = '{addr: load_held ? pix_addr : held_addr,
                          data: {16'h0, load_held ? pix_p : held_p}, strb: STRB_LO};
            end else begin
                push1 = 1'b1;
                word1 = '{addr: load_held ? pix_addr : held_addr,
                          data: {16'h0, load_held ? pix_p : held_p}, strb: STRB_LO};
            end
        end
        free_after = int'(fifo_free) + int'(pop) - int'(push0) - int'(push1);
    end

    always_ff @(posedge clk) begin
        if (!rst || ProcessInit) begin
            state     <= EMPTY;
            held_p    <= '0;
            held_x    <= '0;
            held_y    <= '0;
            held_addr <= '0;
            in_ready  <= 1'b1;
            WordCount <= '0;
        end else begin
            state <= hold_next ? HELD : EMPTY;
            if (load_held) begin
                held_p    <= pix_p;
                held_x    <= bus.InPixelX;
                held_y    <= bus.InPixelY;
                held_addr <= pix_addr;
            end
            // Registered so an accepted pixel always has room for its two pushes.
            in_ready <= (free_after >= 2);
            if (pop) WordCount <= WordCount + 32'd1;
        end
    end

    jpeg_fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (ProcessInit),
        .push0      (push0),
        .push0_word (word0),
        .push1      (push1),
        .push1_word (word1),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .free       (fifo_free)
    );

    assign bus.InReady = in_ready;
    assign bus.WrValid = !fifo_empty;
    assign bus.WrAddr  = ADDR_W'(head.addr);
    assign bus.WrData  = head.data;
    assign bus.WrStrb  = head.strb;
    assign Idle        = (state == EMPTY) && fifo_empty;

endmodule

// File: tb/tb_jpeg_fb_writer.sv
// Self-checking bench for jpeg_fb_writer: a queue-based model of the pairing
// rules is compared against the DUT every cycle, plus literal directed checks.
module tb_jpeg_fb_writer;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ProcessInit = 1'b0;
    logic [31:0] FbBase = 32'h1000_0000;
    logic [15:0] FbStride = 16'd320;
    logic        Flush = 1'b0;
    logic        Idle;
    logic [31:0] WordCount;

    int pass_cnt = 0;
    int total_cnt = 0;

    jpeg_fb_if #(.ADDR_W(32)) bus ();

    jpeg_fb_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ProcessInit (ProcessInit),
        .FbBase      (FbBase),
        .FbStride    (FbStride),
        .Flush       (Flush),
        .bus         (bus.master),
        .Idle        (Idle),
        .WordCount   (WordCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    wr_t         q[$];
    bit          m_ok = 0;
    bit          m_held = 0;
    logic [15:0] mhx, mhy, mhp;
    logic [31:0] m_cnt = 0;

    function automatic logic [15:0] pack565(input logic [7:0] r, g, b);
        return (16'(r) / 16'd8) * 16'd2048 + (16'(g) / 16'd4) * 16'd32 + 16'(b) / 16'd8;
    endfunction

    function automatic logic [31:0] addrOf(input logic [15:0] x, y);
        logic [31:0] prod;
        prod = 32'(y) * 32'(FbStride) + 32'(x - (x % 16'd2));
        return FbBase + prod * 32'd2;
    endfunction

    task automatic modelPixel(input logic [15:0] x, y, input logic [7:0] r, g, b);
        logic [15:0] p;
        p = pack565(r, g, b);
        if (m_held && y == mhy && x == mhx + 16'd1) begin
            q.push_back('{addrOf(mhx, mhy), {p, mhp}, 4'hF});
            m_held = 0;
            return;
        end
        if (m_held) begin
            q.push_back('{addrOf(mhx, mhy), {16'h0, mhp}, 4'h3});
            m_held = 0;
        end
        if (x % 16'd2 == 16'd0) begin
            m_held = 1; mhx = x; mhy = y; mhp = p;
        end else begin
            q.push_back('{addrOf(x, y), {p, 16'h0}, 4'hC});
        end
    endtask

    always @(negedge clk) begin
        bit acc;
        if (m_ok) begin
            checkOutput("wr_valid", bus.WrValid, q.size() != 0);
            checkOutput("wr_addr", bus.WrAddr, q.size() != 0 ? q[0].addr : 32'h0);
            checkOutput("wr_data", bus.WrData, q.size() != 0 ? q[0].data : 32'h0);
            checkOutput("wr_strb", bus.WrStrb, q.size() != 0 ? q[0].strb : 4'h0);
            checkOutput("in_ready", bus.InReady, (DEPTH - q.size()) >= 2);
            checkOutput("idle", Idle, !m_held && q.size() == 0);
            checkOutput("word_count", WordCount, m_cnt);
        end
        if (!rst || ProcessInit) begin
            q.delete(); m_held = 0; m_cnt = 0; m_ok = 1;
        end else if (m_ok) begin
            acc = bus.InEnable && ((DEPTH - q.size()) >= 2);
            if (q.size() != 0 && bus.WrReady) begin
                void'(q.pop_front());
                m_cnt++;
            end
            if (acc) modelPixel(bus.InPixelX, bus.InPixelY, bus.InR, bus.InG, bus.InB);
            if (Flush && m_held) begin
                q.push_back('{addrOf(mhx, mhy), {16'h0, mhp}, 4'h3});
                m_held = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input logic en, input logic [15:0] x, y,
                                 input logic [7:0] r, g, b, input logic fl);
        bus.InEnable = en; bus.InPixelX = x; bus.InPixelY = y;
        bus.InR = r; bus.InG = g; bus.InB = b; Flush = fl;
        @(posedge clk); #1;
        bus.InEnable = 1'b0; Flush = 1'b0;
    endtask

    task automatic sendPixel(input logic [15:0] x, y, input logic [7:0] r, g, b);
        bit rdy = 0;
        bus.InEnable = 1'b1; bus.InPixelX = x; bus.InPixelY = y;
        bus.InR = r; bus.InG = g; bus.InB = b;
        for (int i = 0; i < 200 && !rdy; i++) begin
            @(negedge clk); rdy = bus.InReady;
            @(posedge clk); #1;
        end
        bus.InEnable = 1'b0;
        if (!rdy) checkOutput("send_timeout", 0, 1);
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #1;
            done = Idle;
        end
        if (!done) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic pulseInit();
        ProcessInit = 1'b1;
        @(posedge clk); #1;
        ProcessInit = 1'b0;
    endtask

    initial begin
        logic [15:0] rx, ry;
        bus.InEnable = 0; bus.InPixelX = 0; bus.InPixelY = 0;
        bus.InR = 0; bus.InG = 0; bus.InB = 0; bus.WrReady = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", bus.InReady, 1);
        checkOutput("rst_wr_valid", bus.WrValid, 0);
        checkOutput("rst_idle", Idle, 1);
        checkOutput("rst_count", WordCount, 0);
        checkOutput("rst_addr", bus.WrAddr, 0);
        rst = 1'b1;
        bus.WrReady = 1'b1;

        // pair of adjacent pixels
        applyStimulus(1, 0, 0, 8'hFF, 8'h00, 8'hFF, 0);
        checkOutput("pair_not_yet", bus.WrValid, 0);
        applyStimulus(1, 1, 0, 8'hFF, 8'hFF, 8'hFF, 0);
        checkOutput("pair_valid", bus.WrValid, 1);
        checkOutput("pair_addr", bus.WrAddr, 32'h1000_0000);
        checkOutput("pair_data", bus.WrData, 32'hFFFF_F81F);
        checkOutput("pair_strb", bus.WrStrb, 4'hF);

        // lone odd pixel
        applyStimulus(1, 3, 2, 8'h00, 8'hFF, 8'h00, 0);
        checkOutput("odd_addr", bus.WrAddr, 32'h1000_0504);
        checkOutput("odd_data", bus.WrData, 32'h07E0_0000);
        checkOutput("odd_strb", bus.WrStrb, 4'hC);

        // broken pair then flush
        applyStimulus(1, 4, 1, 8'h08, 8'h04, 8'h08, 0);
        applyStimulus(1, 6, 1, 8'h08, 8'h04, 8'h08, 0);
        checkOutput("break_addr", bus.WrAddr, 32'h1000_0288);
        checkOutput("break_data", bus.WrData, 32'h0000_0821);
        checkOutput("break_strb", bus.WrStrb, 4'h3);
        checkOutput("break_held", Idle, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("flush_addr", bus.WrAddr, 32'h1000_028C);
        checkOutput("flush_data", bus.WrData, 32'h0000_0821);
        checkOutput("flush_strb", bus.WrStrb, 4'h3);
        waitIdle();
        checkOutput("count_after_directed", WordCount, 4);

        // backpressure
        pulseInit();
        bus.WrReady = 1'b0;
        for (int x = 0; x < 14; x++) sendPixel(16'(x), 5, 8'(x * 17), 8'(x * 5), 8'(255 - x));
        checkOutput("bp_ready_low", bus.InReady, 0);
        checkOutput("bp_valid", bus.WrValid, 1);
        bus.WrReady = 1'b1;
        for (int x = 14; x < 20; x++) sendPixel(16'(x), 5, 8'(x * 17), 8'(x * 5), 8'(255 - x));
        waitIdle();
        checkOutput("bp_count", WordCount, 10);

        // ProcessInit mid-stream
        bus.WrReady = 1'b0;
        for (int x = 0; x < 7; x++) sendPixel(16'(x), 7, 8'h40, 8'h80, 8'hC0);
        checkOutput("pi_busy", Idle, 0);
        pulseInit();
        checkOutput("pi_valid", bus.WrValid, 0);
        checkOutput("pi_idle", Idle, 1);
        checkOutput("pi_count", WordCount, 0);
        checkOutput("pi_ready", bus.InReady, 1);

        // synchronous reset
        sendPixel(1, 9, 8'h12, 8'h34, 8'h56);
        checkOutput("sr_valid_before", bus.WrValid, 1);
        rst = 1'b0;
        #2;
        checkOutput("sr_no_async", bus.WrValid, 1);
        @(posedge clk); #1;
        checkOutput("sr_valid", bus.WrValid, 0);
        checkOutput("sr_idle", Idle, 1);
        checkOutput("sr_data", bus.WrData, 0);
        rst = 1'b1;

        // randomized phase
        FbBase = $urandom & 32'hFFFF_FFFC;
        FbStride = 16'($urandom_range(0, 32767) * 2);
        pulseInit();
        rx = 0; ry = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom % 4 != 0) rx = rx + 16'd1;
            else rx = 16'($urandom_range(0, 63));
            if ($urandom % 8 == 0) ry = 16'($urandom_range(0, 7));
            if ($urandom % 64 == 0) ry = 16'($urandom);
            bus.WrReady = ($urandom % 4 != 0) || (c % 200 < 20 ? 1'b0 : 1'b0);
            if (c % 200 < 20) bus.WrReady = 1'b0;
            if ($urandom % 400 == 0) begin
                FbBase = $urandom & 32'hFFFF_FFFC;
                FbStride = 16'($urandom_range(0, 32767) * 2);
                ProcessInit = 1'b1;
            end
            applyStimulus($urandom % 4 != 0, rx, ry, 8'($urandom), 8'($urandom), 8'($urandom),
                          bus.InReady && ($urandom % 16 == 0));
            ProcessInit = 1'b0;
        end

        bus.WrReady = 1'b1;
        for (int i = 0; i < 50 && !bus.InReady; i++) begin @(posedge clk); #1; end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        waitIdle();
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
